// File: rtl/pdua_int_ctrl.sv
// pdua_int_ctrl: prioritised, maskable, single-level interrupt controller
// feeding the INT condition input of the PDUA microprogrammed control unit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   irq             peripheral request lines (rising edge = request)
//   mask_we         mask register write strobe
//   mask_wdata      new mask value (1 = source enabled)
//   ien_set/ien_clr microcode EI / DI pulses (DI wins)
//   int_ack         microcode pulse: vector has been fetched
//   iret            microcode pulse: service routine finished
//   INT             registered interrupt request to the control unit
//   vector          registered vector address of the selected source
//   pending         latched request bits
//   in_service      one-hot source under service, 0 when none
//   mask            current mask register
//   ien             global interrupt enable
module pdua_int_ctrl #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned VEC_WIDTH = 8,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE = 8'hF8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     irq,
  input  logic                 mask_we,
  input  logic [N_SRC-1:0]     mask_wdata,
  input  logic                 ien_set,
  input  logic                 ien_clr,
  input  logic                 int_ack,
  input  logic                 iret,
  output logic                 INT,
  output logic [VEC_WIDTH-1:0] vector,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     in_service,
  output logic [N_SRC-1:0]     mask,
  output logic                 ien
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_SRC-1:0]     irq_q;
  logic [N_SRC-1:0]     pending_q, pending_d;
  logic [N_SRC-1:0]     in_service_q, in_service_d;
  logic [N_SRC-1:0]     mask_q, mask_d;
  logic                 ien_q, ien_d;
  logic                 int_q, int_d;
  logic [VEC_WIDTH-1:0] vector_q, vector_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [N_SRC-1:0]     rise;
  logic [N_SRC-1:0]     eligible;
  logic                 any_elig;
  logic [IDX_W-1:0]     sel;
  logic [N_SRC-1:0]     idx_onehot;
  logic [N_SRC-1:0]     ack_clr;
  logic                 hw_ien_set;
  logic                 hw_ien_clr;

  assign rise       = irq & ~irq_q;
  assign eligible   = pending_q & mask_q;
  assign any_elig   = |eligible;
  assign idx_onehot = N_SRC'(1) << idx_q;

  // Priority encoder: lowest eligible index wins.
  always_comb begin
    sel = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IDX_W'(i);
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d      = state_q;
    int_d        = 1'b0;
    vector_d     = vector_q;
    idx_d        = idx_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    hw_ien_set   = 1'b0;
    hw_ien_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ien_q && any_elig) begin
          state_d  = REQ;
          int_d    = 1'b1;
          idx_d    = sel;
          vector_d = VEC_BASE + VEC_WIDTH'(sel);
        end
      end
      REQ: begin
        if (!ien_q || !any_elig) begin
          state_d = IDLE;
        end else if (int_ack) begin
          // Ack services the index latched last cycle, so a same-cycle
          // mask write cannot redirect it. Vector holds.
          ack_clr      = idx_onehot;
          in_service_d = idx_onehot;
          hw_ien_clr   = 1'b1;
          state_d      = SERVICE;
        end else begin
          // Keep re-selecting so a higher-priority arrival pre-empts.
          int_d    = 1'b1;
          idx_d    = sel;
          vector_d = VEC_BASE + VEC_WIDTH'(sel);
        end
      end
      SERVICE: begin
        if (iret) begin
          in_service_d = '0;
          hw_ien_set   = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // New edges win over the ack clear of the same bit.
  assign pending_d = (pending_q & ~ack_clr) | rise;

  // Any clear (DI or ack) beats any set (EI or iret).
  assign ien_d = (ien_q | ien_set | hw_ien_set) & ~(ien_clr | hw_ien_clr);

  assign mask_d = mask_we ? mask_wdata : mask_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      ien_q        <= 1'b0;
      int_q        <= 1'b0;
      vector_q     <= VEC_BASE;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      ien_q        <= ien_d;
      int_q        <= int_d;
      vector_q     <= vector_d;
      idx_q        <= idx_d;
    end
  end

  assign INT        = int_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;
  assign ien        = ien_q;

endmodule

// File: doc/pdua_int_ctrl.md
Name: pdua_int_ctrl

Overview:
- Prioritised, maskable interrupt controller that drives the INT condition input of the microprogrammed control unit.
- Latches rising edges on up to N_SRC peripheral request lines into pending bits and applies a mask register and a global enable.
- Raises INT and presents a vector address.
- Microcode handshakes with it through int_ack (vector fetched) and iret (return from service). Single-level: no nesting.

Parameters:
- N_SRC, 4, number of interrupt sources, legal 1..8; index 0 is highest priority.
- VEC_WIDTH, 8, width of vector output (matches the PDUA address bus).
- VEC_BASE, 8'hF8, vector of source 0; source i vector = VEC_BASE + i, modulo 2^VEC_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq  input  N_SRC  peripheral requests, synchronous to clk; a rising edge is a request.
- mask_we  input  1  write strobe for mask register.
- mask_wdata  input  N_SRC  new mask; 1 = source enabled.
- ien_set  input  1  microcode EI pulse.
- ien_clr  input  1  microcode DI pulse.
- int_ack  input  1  microcode pulse: vector has been taken.
- iret  input  1  microcode pulse: service routine finished.
- INT  output  1  interrupt request to the control unit, registered.
- vector  output  VEC_WIDTH  vector of the selected source, registered.
- pending  output  N_SRC  pending bits.
- in_service  output  N_SRC  one-hot source being serviced, 0 if none.
- mask  output  N_SRC  current mask register.
- ien  output  1  global interrupt enable.

Behaviour:
- Reset (async): state=IDLE, INT=0, vector=VEC_BASE, pending=0, in_service=0, mask=0, ien=0, irq_q=0. An irq held high across reset release therefore counts as an edge on the first clock.
- Edge detect: rise[i] = irq[i] & ~irq_q[i]; irq_q <= irq every cycle.
- pending[i]: set on rise[i]; cleared on int_ack when i is the selected idx. If set and clear fall in the same cycle, set wins.
- eligible = pending & mask. sel = lowest set index of eligible.
- ien: ien_clr has priority over ien_set. ien is also cleared by hardware on int_ack and set by hardware on iret.
- mask: mask <= mask_wdata on mask_we; takes effect the next cycle.
- FSM states:
  - IDLE, INT=0: if ien and eligible!=0, go to REQ and latch idx=sel, vector=VEC_BASE+sel.
  - REQ, INT=1:
    - If ien=0 or eligible=0 (masked, or ien cleared), return to IDLE with INT=0.
    - Else if int_ack: clear pending[idx], set in_service=onehot(idx), set ien=0, go to SERVICE with INT=0. vector holds.
    - Else re-evaluate idx/vector each cycle: a higher-priority source arriving before ack pre-empts the selection.
  - SERVICE, INT=0: int_ack ignored. On iret: in_service=0, ien=1, go to IDLE. Pending bits keep accumulating meanwhile.
- Ignored inputs: iret in IDLE/REQ; int_ack in IDLE/SERVICE.
- Latency: irq rising before edge E0 → pending set at E0 → INT=1 after E1 (2 cycles). A new request after iret: INT rises 1 cycle after the iret edge if eligible.
- Same-cycle int_ack and mask_we: ack uses the pre-write mask (idx already latched).
- Reset asserted mid-REQ/SERVICE: immediate return to reset values. No ack or iret is required afterwards.

Test Plan:
- Basic path:
  - Stimulus: mask=4'b1111, ien_set, irq[2] pulse.
  - Response: pending=4'b0100 at next edge; INT=1 and vector=8'hFA one cycle later; int_ack → INT=0, in_service=4'b0100, pending=0, ien=0; iret → in_service=0, ien=1, IDLE.
- Priority and pre-emption:
  - Stimulus: irq[3] rises, then irq[1] rises while in REQ (before ack).
  - Response: vector changes 8'hFB→8'hF9; ack services source 1 only; pending=4'b1000 remains; after iret INT re-asserts with vector 8'hFB.
- Mask and enable:
  - irq[0] edge with mask=4'b1110 → pending[0]=1, INT stays 0.
  - Writing mask=4'b0001 → INT=1, vector=8'hF8.
  - ien_set and ien_clr same cycle → ien=0.
  - ien_clr while in REQ → INT=0, state IDLE.
- Simultaneous set/clear: irq[1] edge in the same cycle as int_ack for source 1 → in_service=4'b0010, pending[1] stays 1, INT re-raised after iret.
- Nesting blocked: in SERVICE, irq[0] edge → pending[0]=1, INT=0 until iret, then INT=1 one cycle after the iret edge.
- Reset mid-operation: assert rst asynchronously during SERVICE → INT=0, in_service=0, mask=0, ien=0, vector=8'hF8 immediately, no clock needed; irq held high across release → pending bit set on first clock.
